// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds the PC, addresses instruction memory and
// registers the returned word with its address for decode.
module pc_fetch_unit #(
   parameter int unsigned       ADDR_W   = 4,
   parameter int unsigned       INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0]        HALT_OPC = 4'hF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic [INSTR_W-1:0] instr_in,
   output logic [ADDR_W-1:0]  read,
   output logic [INSTR_W-1:0] instr_out,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               halted,
   output logic               wrap
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

   logic [1:0]         state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
   logic               valid_q, valid_d;
   logic               wrap_q, wrap_d;

   logic in_run;
   logic do_branch;
   logic do_stall;
   logic do_fetch;
   logic is_halt_word;
   logic pc_at_max;

   // Action for this edge; a branch beats a stall, a stall beats a fetch.
   assign in_run       = (state_q == S_RUN);
   assign do_branch    = in_run & branch_taken;
   assign do_stall     = in_run & ~branch_taken & stall;
   assign do_fetch     = in_run & ~branch_taken & ~stall;
   assign is_halt_word = (instr_in[INSTR_W-1 -: 4] == HALT_OPC);
   assign pc_at_max    = &pc_q;

   // Mode sequencing: start leaves IDLE/HALT, a fetched halt word enters HALT.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_RUN;
         end
         S_RUN: begin
            if (do_fetch && is_halt_word) state_d = S_HALT;
         end
         S_HALT: begin
            if (start) state_d = S_RUN;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Program counter: redirect, advance (wrapping modulo 2^ADDR_W) or hold.
   always_comb begin
      pc_d = pc_q;
      unique case (1'b1)
         do_branch: pc_d = branch_target;
         do_fetch:  pc_d = pc_q + PC_ONE;
         default:   pc_d = pc_q;
      endcase
   end

   // Fetch register: capture on a fetch, drop valid on flush or when parked.
   always_comb begin
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;
      wrap_d   = 1'b0;
      unique case (1'b1)
         !in_run: begin
            valid_d = 1'b0;
         end
         do_branch: begin
            valid_d = 1'b0;
         end
         do_stall: begin
            valid_d = valid_q;
         end
         do_fetch: begin
            instr_d  = instr_in;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            wrap_d   = pc_at_max;
         end
         default: begin
            valid_d = valid_q;
         end
      endcase
   end

   // State and PC registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Fetch register and wrap pulse, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q  <= '0;
         pc_out_q <= '0;
         valid_q  <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
         valid_q  <= valid_d;
         wrap_q   <= wrap_d;
      end
   end

   assign read        = pc_q;
   assign instr_out   = instr_q;
   assign instr_valid = valid_q;
   assign pc_out      = pc_out_q;
   assign halted      = (state_q == S_HALT);
   assign wrap        = wrap_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then random
// control traffic, checked against a cycle-level reference model.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stall;
   logic        branch_taken;
   logic [3:0]  branch_target;
   logic [15:0] instr_in;
   logic [3:0]  read;
   logic [15:0] instr_out;
   logic        instr_valid;
   logic [3:0]  pc_out;
   logic        halted;
   logic        wrap;

   logic [15:0] mem [16];
   bit          force_en;
   logic [15:0] force_val;

   int checks = 0;
   int errors = 0;

   // reference model: mode 0 idle, 1 running, 2 halted
   int          m_mode;
   int          m_pc;
   logic [15:0] m_iout;
   int          m_pcout;
   bit          m_valid;
   bit          m_wrap;

   always #5 clk = ~clk;

   assign instr_in = force_en ? force_val : mem[read];

   pc_fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instr_in      (instr_in),
      .read          (read),
      .instr_out     (instr_out),
      .instr_valid   (instr_valid),
      .pc_out        (pc_out),
      .halted        (halted),
      .wrap          (wrap)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, ".read"},   32'(read),        32'(m_pc));
      chk({tag, ".instr"},  32'(instr_out),   32'(m_iout));
      chk({tag, ".valid"},  32'(instr_valid), 32'(m_valid));
      chk({tag, ".pc_out"}, 32'(pc_out),      32'(m_pcout));
      chk({tag, ".halted"}, 32'(halted),      32'(m_mode == 2));
      chk({tag, ".wrap"},   32'(wrap),        32'(m_wrap));
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_pc    = 0;
      m_iout  = '0;
      m_pcout = 0;
      m_valid = 0;
      m_wrap  = 0;
   endtask

   task automatic model_edge(bit st, bit sl, bit br, int tgt, logic [15:0] w);
      m_wrap = 0;
      if (m_mode == 1) begin
         if (br) begin
            m_pc    = tgt;
            m_valid = 0;
         end else if (!sl) begin
            m_iout  = w;
            m_pcout = m_pc;
            m_valid = 1;
            m_wrap  = (m_pc == 15);
            m_pc    = (m_pc + 1) % 16;
            if (w[15:12] == 4'hF) m_mode = 2;
         end
      end else begin
         m_valid = 0;
         if (st) m_mode = 1;
      end
   endtask

   task automatic step(bit st, bit sl, bit br, logic [3:0] tgt);
      logic [15:0] w;
      @(negedge clk);
      start         = st;
      stall         = sl;
      branch_taken  = br;
      branch_target = tgt;
      w = force_en ? force_val : mem[m_pc];
      @(posedge clk);
      model_edge(st, sl, br, int'(tgt), w);
      #1;
      check_all("step");
   endtask

   task automatic do_reset(bit with_start);
      #2;
      rst   = 1'b1;
      start = with_start;
      #1;
      model_reset();
      check_all("rst_async");
      @(posedge clk);
      #1;
      check_all("rst_hold");
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
   endtask

   task automatic run_to_pc(int target);
      for (int i = 0; i < 40 && m_pc != target; i++) step(0, 0, 0, 4'd0);
      chk("reach_pc", 32'(read), 32'(target));
   endtask

   initial begin
      rst           = 1'b0;
      start         = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 4'd0;
      force_en      = 0;
      force_val     = '0;
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom) & 16'h7FFF;
      mem[0] = 16'h0120;
      mem[1] = 16'h8111;
      mem[2] = 16'h8111;

      // reset with start held: reset must win
      do_reset(1'b1);
      chk("t1_read", 32'(read), 32'h0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 4'd9);
      chk("t1_idle_read", 32'(read), 32'h0);
      chk("t1_idle_valid", 32'(instr_valid), 32'h0);

      // start, then three fetches
      step(1, 0, 0, 4'd0);
      step(0, 0, 0, 4'd0);
      chk("t2_e1", 32'(instr_out), 32'h0120);
      chk("t2_v1", 32'(instr_valid), 32'h1);
      step(0, 0, 0, 4'd0);
      chk("t2_e2", 32'(instr_out), 32'h8111);
      chk("t2_p2", 32'(pc_out), 32'h1);
      step(0, 0, 0, 4'd0);
      chk("t2_p3", 32'(pc_out), 32'h2);
      step(1, 0, 0, 4'd0);

      // stall two cycles at read=5
      run_to_pc(5);
      step(0, 1, 0, 4'd0);
      step(0, 1, 0, 4'd0);
      chk("t4_read", 32'(read), 32'h5);
      chk("t4_pcout", 32'(pc_out), 32'h4);
      step(0, 0, 0, 4'd0);
      chk("t4_rel_read", 32'(read), 32'h6);
      chk("t4_rel_pcout", 32'(pc_out), 32'h5);

      // branch together with stall when pc_out=11
      run_to_pc(12);
      chk("t5_pcout", 32'(pc_out), 32'd11);
      step(0, 1, 1, 4'd7);
      chk("t5_read", 32'(read), 32'h7);
      chk("t5_bubble", 32'(instr_valid), 32'h0);
      step(0, 0, 0, 4'd0);
      chk("t5_instr", 32'(instr_out), 32'(mem[7]));
      chk("t5_pc7", 32'(pc_out), 32'h7);

      // wrap from 15 to 0
      run_to_pc(15);
      step(0, 0, 0, 4'd0);
      chk("t3_wrap", 32'(wrap), 32'h1);
      chk("t3_read0", 32'(read), 32'h0);
      chk("t3_pc15", 32'(pc_out), 32'hF);
      step(0, 0, 0, 4'd0);
      chk("t3_wrap_off", 32'(wrap), 32'h0);

      // halt word at read=3, restart at 4
      run_to_pc(3);
      force_en  = 1;
      force_val = 16'hF000;
      step(0, 0, 0, 4'd0);
      force_en = 0;
      chk("t6_instr", 32'(instr_out), 32'hF000);
      chk("t6_halted", 32'(halted), 32'h1);
      chk("t6_read", 32'(read), 32'h4);
      step(0, 1, 1, 4'd9);
      chk("t6_valid_drop", 32'(instr_valid), 32'h0);
      chk("t6_read_hold", 32'(read), 32'h4);
      step(1, 0, 0, 4'd0);
      step(0, 0, 0, 4'd0);
      chk("t6_resume", 32'(pc_out), 32'h4);
      step(0, 0, 0, 4'd0);

      // asynchronous reset mid-run
      do_reset(1'b0);
      chk("t6_rst_valid", 32'(instr_valid), 32'h0);

      // random control traffic over a random program
      for (int i = 0; i < 16; i++) begin
         mem[i] = 16'($urandom);
         if ($urandom_range(0, 5) != 0 && mem[i][15:12] == 4'hF)
            mem[i][15:12] = 4'hE;
      end
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 60) == 0) begin
            do_reset(1'($urandom_range(0, 1)));
         end else begin
            if ($urandom_range(0, 20) == 0) begin
               int a;
               a = $urandom_range(0, 15);
               mem[a] = 16'($urandom);
            end
            step($urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0,
                 4'($urandom_range(0, 15)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
